button_gesture_decoder: RTL and testbench

BUTTON_GESTURE_DECODER -- requirements
Module: button_gesture_decoder

---
 rtl/gesture_pkg.sv | 20 ++
 rtl/button_debouncer.sv | 49 ++++
 rtl/button_gesture_decoder.sv | 155 +++++++++++++++
 tb/tb_button_gesture_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_pkg.sv
// Shared types for the button gesture path: the gesture code seen by downstream
// stages and the classifier state encoding.
package gesture_pkg;

    typedef enum logic [1:0] {
        G_NONE   = 2'b00,
        G_TAP    = 2'b01,
        G_DOUBLE = 2'b10,
        G_LONG   = 2'b11
    } gesture_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS1    = 3'd1,
        S_GAP       = 3'd2,
        S_PRESS2    = 3'd3,
        S_LONG_HELD = 3'd4
    } fsm_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a counting debouncer; button_clean only
// follows the synchronised level after DEBOUNCE_CYCLES consecutive differing samples.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic Clock,
    input  logic nReset,
    input  logic button,
    output logic button_clean
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          button_s;
    logic          clean_r;
    logic [CW-1:0] cnt_r;

    // Synchroniser for the asynchronous raw input (idle level is high).
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync1_r  <= 1'b1;
            button_s <= 1'b1;
        end else begin
            sync1_r  <= button;
            button_s <= sync1_r;
        end
    end

    // Any sample that agrees with the accepted level restarts the count.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            clean_r <= 1'b1;
            cnt_r   <= '0;
        end else if (button_s == clean_r) begin
            cnt_r   <= '0;
        end else if (cnt_r == CNT_LAST) begin
            clean_r <= button_s;
            cnt_r   <= '0;
        end else begin
            cnt_r   <= cnt_r + CNT_ONE;
        end
    end

    assign button_clean = clean_r;

endmodule

// File: rtl/button_gesture_decoder.sv
// Debounced pushbutton classifier: turns press/release timing into single-cycle
// TAP, DOUBLE and LONG strobes.
module button_gesture_decoder
    import gesture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int GAP_CYCLES      = 12500000
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       button,
    output logic       button_clean,
    output logic       gesture_valid,
    output logic [1:0] gesture_code,
    output logic       busy
);

    localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES);
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam int ACW = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [ACW-1:0] ARM_LAST = ACW'(DEBOUNCE_CYCLES + 2);
    localparam logic [ACW-1:0] ARM_ONE  = ACW'(1);

    logic           clean_s;
    logic           clean_prev_r;
    logic           armed_r;
    logic [ACW-1:0] arm_cnt_r;
    logic           press_s;
    logic           release_s;
    fsm_state_t     state_r;
    fsm_state_t     state_next_s;
    logic [TW-1:0]  timer_r;
    logic [TW-1:0]  timer_next_s;
    gesture_t       strobe_s;
    logic           valid_r;
    gesture_t       code_r;
    logic           busy_r;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .Clock       (Clock),
        .nReset      (nReset),
        .button      (button),
        .button_clean(clean_s)
    );

    // Edge detector on the debounced level.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            clean_prev_r <= 1'b1;
        end else begin
            clean_prev_r <= clean_s;
        end
    end

    // A button held through reset shows up as a late falling edge; ignore presses
    // until a release is seen or the level has stayed high past the debounce latency.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            armed_r   <= 1'b0;
            arm_cnt_r <= '0;
        end else if (armed_r) begin
            armed_r   <= 1'b1;
        end else if (release_s) begin
            armed_r   <= 1'b1;
        end else if (!clean_s) begin
            arm_cnt_r <= '0;
        end else if (arm_cnt_r == ARM_LAST) begin
            armed_r   <= 1'b1;
        end else begin
            arm_cnt_r <= arm_cnt_r + ARM_ONE;
        end
    end

    assign press_s   = armed_r & clean_prev_r & ~clean_s;
    assign release_s = ~clean_prev_r & clean_s;

    // Next-state, shared timer and strobe decision; events win over timer expiry.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        strobe_s     = G_NONE;
        case (state_r)
            S_IDLE: begin
                if (press_s) state_next_s = S_PRESS1;
                else         state_next_s = S_IDLE;
            end
            S_PRESS1: begin
                if (release_s) begin
                    state_next_s = S_GAP;
                end else if (timer_r == LONG_LAST) begin
                    state_next_s = S_LONG_HELD;
                    strobe_s     = G_LONG;
                end else begin
                    timer_next_s = timer_r + TIMER_ONE;
                end
            end
            S_GAP: begin
                if (press_s) begin
                    state_next_s = S_PRESS2;
                end else if (timer_r == GAP_LAST) begin
                    state_next_s = S_IDLE;
                    strobe_s     = G_TAP;
                end else begin
                    timer_next_s = timer_r + TIMER_ONE;
                end
            end
            S_PRESS2: begin
                if (release_s) begin
                    state_next_s = S_IDLE;
                    strobe_s     = G_DOUBLE;
                end else begin
                    state_next_s = S_PRESS2;
                end
            end
            S_LONG_HELD: begin
                if (release_s) state_next_s = S_IDLE;
                else           state_next_s = S_LONG_HELD;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
        if (state_next_s != state_r) timer_next_s = '0;
        else                         timer_next_s = timer_next_s;
    end

    // State, timer and registered outputs.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r <= S_IDLE;
            timer_r <= '0;
            valid_r <= 1'b0;
            code_r  <= G_NONE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
            valid_r <= (strobe_s != G_NONE);
            code_r  <= strobe_s;
            busy_r  <= (state_next_s != S_IDLE);
        end
    end

    assign button_clean  = clean_s;
    assign gesture_valid = valid_r;
    assign gesture_code  = code_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Scoreboard bench for button_gesture_decoder with short debounce/long/gap timings.
module tb_button_gesture_decoder;
    import gesture_pkg::*;

    localparam int DEB = 4;
    localparam int LNG = 32;
    localparam int GAP = 16;
    // Raw edge driven after edge N: button_clean moves at N+DEB+2, FSM reacts at N+DEB+3.
    localparam int TAP_LAT    = DEB + 3 + GAP;
    localparam int LONG_LAT   = DEB + 3 + LNG;
    localparam int DOUBLE_LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       button = 1'b1;
    logic       button_clean;
    logic       gesture_valid;
    logic [1:0] gesture_code;
    logic       busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] code;
        int         at;
    } exp_t;
    exp_t sb[$];

    button_gesture_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG),
        .GAP_CYCLES     (GAP)
    ) dut (
        .Clock        (clk),
        .nReset       (rst_n),
        .button       (button),
        .button_clean (button_clean),
        .gesture_valid(gesture_valid),
        .gesture_code (gesture_code),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Strobe monitor: pops the scoreboard on every strobe, code must be NONE otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (gesture_valid) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_strobe", 32'(gesture_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("gesture_code", 32'(gesture_code), 32'(e.code));
                    check_eq("gesture_cycle", cyc, e.at);
                end
            end else begin
                check_eq("idle_code", 32'(gesture_code), 32'(G_NONE));
            end
        end
    end

    task automatic push(input logic [1:0] code, input int at);
        exp_t e;
        e.code = code;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_clean", 32'(button_clean), 32'd1);
        check_eq("rst_valid", 32'(gesture_valid), 32'd0);
        check_eq("rst_code", 32'(gesture_code), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        resync();
        rst_n = 1'b1;
        goto(cyc + 12);

        // Short glitch is rejected entirely.
        button = 1'b0;
        goto(cyc + 3);
        button = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check_eq("glitch_clean", 32'(button_clean), 32'd1);
            check_eq("glitch_busy", 32'(busy), 32'd0);
        end
        resync();

        // Clean 10-cycle press: debounce latency, single TAP, busy drops.
        n0 = cyc;
        button = 1'b0;
        at_neg(n0 + DEB + 1);
        check_eq("tap_clean_before", 32'(button_clean), 32'd1);
        at_neg(n0 + DEB + 2);
        check_eq("tap_clean_fall", 32'(button_clean), 32'd0);
        resync();
        goto(n0 + 10);
        button = 1'b1;
        push(G_TAP, n0 + 10 + TAP_LAT);
        at_neg(n0 + 10 + TAP_LAT - 1);
        check_eq("tap_busy_before", 32'(busy), 32'd1);
        at_neg(n0 + 10 + TAP_LAT);
        check_eq("tap_busy_after", 32'(busy), 32'd0);
        resync();
        goto(cyc + 10);

        // Two presses separated by an 8-cycle release: DOUBLE only.
        n0 = cyc;
        button = 1'b0;
        goto(n0 + 10);
        button = 1'b1;
        goto(n0 + 18);
        button = 1'b0;
        goto(n0 + 28);
        button = 1'b1;
        push(G_DOUBLE, n0 + 28 + DOUBLE_LAT);
        goto(cyc + 40);

        // 60-cycle hold: LONG, nothing on release.
        n0 = cyc;
        button = 1'b0;
        push(G_LONG, n0 + LONG_LAT);
        goto(n0 + 60);
        button = 1'b1;
        goto(cyc + 40);
        @(negedge clk);
        check_eq("long_busy_end", 32'(busy), 32'd0);
        resync();

        // Reset during PRESS2 with the button still held.
        n0 = cyc;
        button = 1'b0;
        goto(n0 + 10);
        button = 1'b1;
        goto(n0 + 18);
        button = 1'b0;
        goto(n0 + 30);
        @(negedge clk);
        check_eq("p2_busy", 32'(busy), 32'd1);
        resync();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_clean", 32'(button_clean), 32'd1);
        check_eq("mid_rst_valid", 32'(gesture_valid), 32'd0);
        check_eq("mid_rst_code", 32'(gesture_code), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        resync();
        resync();
        rst_n = 1'b1;
        goto(cyc + 20);
        @(negedge clk);
        check_eq("held_clean", 32'(button_clean), 32'd0);
        check_eq("held_busy", 32'(busy), 32'd0);
        resync();
        button = 1'b1;
        goto(cyc + 20);
        @(negedge clk);
        check_eq("held_release_busy", 32'(busy), 32'd0);
        resync();
        n0 = cyc;
        button = 1'b0;
        goto(n0 + 10);
        button = 1'b1;
        push(G_TAP, n0 + 10 + TAP_LAT);
        goto(cyc + 35);

        // Bouncy press: 2-cycle bounces on both edges still give one TAP.
        n0 = cyc;
        button = 1'b0;
        goto(n0 + 2);
        button = 1'b1;
        goto(n0 + 4);
        button = 1'b0;
        goto(n0 + 14);
        button = 1'b1;
        goto(n0 + 16);
        button = 1'b0;
        goto(n0 + 18);
        button = 1'b1;
        push(G_TAP, n0 + 18 + TAP_LAT);
        goto(cyc + 40);

        check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
